// File: rtl/nios_system_otg_hpi_master.sv
// Avalon-MM slave that runs CY7C67200 HPI read/write cycles with programmable phase timing.
// Optional macro OTG_HPI_IRQ_SYNC_EN: synchronises otg_int into irq (otherwise irq is tied low).
module nios_system_otg_hpi_master #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 2,
  parameter int RECOVER_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_waitrequest,
  input  logic [15:0] otg_data_in,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  input  logic        otg_int,
  output logic        irq
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DONE    = 3'd4,
    ST_RECOVER = 3'd5
  } state_t;

  localparam logic [3:0] L_SETUP   = 4'(SETUP_CYC - 1);
  localparam logic [3:0] L_STROBE  = 4'(STROBE_CYC - 1);
  localparam logic [3:0] L_HOLD    = 4'(HOLD_CYC - 1);
  localparam logic [3:0] L_RECOVER = 4'(RECOVER_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        r_is_rd;
  logic        w_is_rd_nxt;
  logic        w_accept;
  logic        w_capture;
  logic        w_active_nxt;
  logic        r_cs_n;
  logic        r_rd_n;
  logic        r_wr_n;
  logic        r_oe;
  logic [1:0]  r_addr;
  logic [15:0] r_data_out;
  logic [15:0] r_readdata;

  assign w_accept     = (r_state == ST_IDLE) && (avs_read || avs_write);
  assign w_is_rd_nxt  = w_accept ? avs_read : r_is_rd;
  assign w_active_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                        (w_state_nxt == ST_HOLD);

  // Phase sequencing: each phase loads the down-counter with its length minus one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = L_SETUP;
        end else begin
          w_cnt_nxt   = 4'd0;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = L_STROBE;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = L_HOLD;
          w_capture   = r_is_rd;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_RECOVER;
        w_cnt_nxt   = L_RECOVER;
      end
      ST_RECOVER: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State, counter and request latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_is_rd <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_is_rd <= w_is_rd_nxt;
    end
  end

  // Pad outputs are decoded from the next state so every otg_* pin comes straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_n     <= 1'b1;
      r_rd_n     <= 1'b1;
      r_wr_n     <= 1'b1;
      r_oe       <= 1'b0;
      r_addr     <= 2'd0;
      r_data_out <= 16'd0;
      r_readdata <= 16'd0;
    end else begin
      r_cs_n <= !w_active_nxt;
      r_rd_n <= !((w_state_nxt == ST_STROBE) && w_is_rd_nxt);
      r_wr_n <= !((w_state_nxt == ST_STROBE) && !w_is_rd_nxt);
      r_oe   <= w_active_nxt && !w_is_rd_nxt;
      if (w_accept) begin
        r_addr <= avs_address;
        if (!avs_read) begin
          r_data_out <= avs_writedata;
        end
      end
      if (w_capture) begin
        r_readdata <= otg_data_in;
      end
    end
  end

  assign avs_waitrequest = (avs_read || avs_write) && (r_state != ST_DONE);
  assign avs_readdata    = r_readdata;
  assign otg_cs_n        = r_cs_n;
  assign otg_rd_n        = r_rd_n;
  assign otg_wr_n        = r_wr_n;
  assign otg_data_oe     = r_oe;
  assign otg_addr        = r_addr;
  assign otg_data_out    = r_data_out;

`ifdef OTG_HPI_IRQ_SYNC_EN
  logic r_irq_meta;
  logic r_irq;

  // Two-flop synchroniser for the asynchronous chip interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_meta <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_meta <= otg_int;
      r_irq      <= r_irq_meta;
    end
  end

  assign irq = r_irq;
`else
  logic w_unused_int;

  assign w_unused_int = otg_int;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_nios_system_otg_hpi_master.sv
// Randomised bench for nios_system_otg_hpi_master: a default-timing instance and an all-ones timing instance,
// checked cycle by cycle against a phase-window model derived from the timing parameters.
module tb_nios_system_otg_hpi_master;

  localparam int PS[2] = '{2, 1};
  localparam int PT[2] = '{4, 1};
  localparam int PH[2] = '{2, 1};
  localparam int PR[2] = '{2, 1};

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  av_addr [2];
  logic        av_rd   [2];
  logic        av_wr   [2];
  logic [15:0] av_wd   [2];
  logic [15:0] rdata   [2];
  logic        waitr   [2];
  logic [15:0] din     [2];
  logic [15:0] dout    [2];
  logic        oe      [2];
  logic [1:0]  oaddr   [2];
  logic        csn     [2];
  logic        rdn     [2];
  logic        wrn     [2];
  logic        oint    [2];
  logic        irq     [2];

  logic [15:0] exp_rd [2];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nios_system_otg_hpi_master dut0 (
    .clk(clk), .reset_n(reset_n),
    .avs_address(av_addr[0]), .avs_read(av_rd[0]), .avs_write(av_wr[0]),
    .avs_writedata(av_wd[0]), .avs_readdata(rdata[0]), .avs_waitrequest(waitr[0]),
    .otg_data_in(din[0]), .otg_data_out(dout[0]), .otg_data_oe(oe[0]),
    .otg_addr(oaddr[0]), .otg_cs_n(csn[0]), .otg_rd_n(rdn[0]), .otg_wr_n(wrn[0]),
    .otg_int(oint[0]), .irq(irq[0])
  );

  nios_system_otg_hpi_master #(
    .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .RECOVER_CYC(1)
  ) dut1 (
    .clk(clk), .reset_n(reset_n),
    .avs_address(av_addr[1]), .avs_read(av_rd[1]), .avs_write(av_wr[1]),
    .avs_writedata(av_wd[1]), .avs_readdata(rdata[1]), .avs_waitrequest(waitr[1]),
    .otg_data_in(din[1]), .otg_data_out(dout[1]), .otg_data_oe(oe[1]),
    .otg_addr(oaddr[1]), .otg_cs_n(csn[1]), .otg_rd_n(rdn[1]), .otg_wr_n(wrn[1]),
    .otg_int(oint[1]), .irq(irq[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction starting in an idle cycle; ends back in IDLE just after a rising edge.
  task automatic run_txn(input int d, input bit is_rd, input logic [1:0] a, input logic [15:0] v);
    int s, t, h, r, dn;
    logic act, stb;
    logic [4:0] exp5, got5;
    s  = PS[d];
    t  = PT[d];
    h  = PH[d];
    r  = PR[d];
    dn = s + t + h + 1;
    av_addr[d] = a;
    av_rd[d]   = is_rd;
    av_wr[d]   = is_rd ? 1'($urandom_range(0, 1)) : 1'b1;
    av_wd[d]   = is_rd ? 16'($urandom) : v;
    din[d]     = v ^ 16'h5A5A;
    for (int c = 0; c <= dn; c++) begin
      if (c == s + t) din[d] = v;
      else if (c == s + t + 1) din[d] = v ^ 16'hFFFF;
      @(negedge clk);
      act  = (c >= 1) && (c <= s + t + h);
      stb  = (c >= s + 1) && (c <= s + t);
      exp5 = {!act, !(stb && is_rd), !(stb && !is_rd), act && !is_rd, 1'(c != dn)};
      got5 = {csn[d], rdn[d], wrn[d], oe[d], waitr[d]};
      check_val($sformatf("ctl d%0d c%0d", d, c), 32'(got5), 32'(exp5));
      if (act) begin
        check_val($sformatf("addr d%0d c%0d", d, c), 32'(oaddr[d]), 32'(a));
        if (!is_rd) check_val($sformatf("dout d%0d c%0d", d, c), 32'(dout[d]), 32'(v));
      end
      if (c == dn) begin
        if (is_rd) exp_rd[d] = v;
        check_val($sformatf("rdata d%0d", d), 32'(rdata[d]), 32'(exp_rd[d]));
      end
      if (c < dn) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    av_rd[d] = 1'b0;
    av_wr[d] = 1'b0;
    for (int k = 0; k < r; k++) begin
      @(negedge clk);
      check_val($sformatf("recover d%0d", d), 32'({csn[d], rdn[d], wrn[d], oe[d], waitr[d]}), 32'(5'b11100));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc, gap;
    bit seen_low;
    logic [15:0] vr;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      av_addr[d] = 2'd0; av_rd[d] = 1'b0; av_wr[d] = 1'b0; av_wd[d] = 16'd0;
      din[d] = 16'd0; oint[d] = 1'b0; exp_rd[d] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_val("reset ctl", 32'({csn[d], rdn[d], wrn[d], oe[d], waitr[d]}), 32'(5'b11100));
      check_val("reset dout", 32'(dout[d]), 32'd0);
      check_val("reset addr", 32'(oaddr[d]), 32'd0);
      check_val("reset rdata", 32'(rdata[d]), 32'd0);
      check_val("reset irq", 32'(irq[d]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_txn(0, 1'b0, 2'd2, 16'h1234);
    run_txn(0, 1'b1, 2'd0, 16'hBEEF);
    run_txn(1, 1'b0, 2'd1, 16'hA5A5);
    run_txn(1, 1'b1, 2'd3, 16'h0F0F);

    // Back-to-back write then read on the default-timing instance.
    av_addr[0] = 2'd1; av_wr[0] = 1'b1; av_wd[0] = 16'($urandom);
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      if (!waitr[0]) break;
      cyc++;
      @(posedge clk);
      #1;
    end
    check_val("b2b write latency", 32'(cyc), 32'(PS[0] + PT[0] + PH[0] + 1));
    @(posedge clk);
    #1;
    vr = 16'($urandom);
    av_wr[0] = 1'b0; av_rd[0] = 1'b1; av_addr[0] = 2'd3; din[0] = vr;
    gap = 1; cyc = 0; seen_low = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      if (csn[0] && !seen_low) gap++;
      else seen_low = 1'b1;
      if (!waitr[0]) break;
      cyc++;
      @(posedge clk);
      #1;
    end
    check_val("b2b cs gap ok", 32'(gap >= PR[0] + 1), 32'd1);
    check_val("b2b read latency", 32'(cyc), 32'(PR[0] + PS[0] + PT[0] + PH[0] + 1));
    check_val("b2b rdata", 32'(rdata[0]), 32'(vr));
    exp_rd[0] = vr;
    @(posedge clk);
    #1;
    av_rd[0] = 1'b0;
    repeat (PR[0]) @(posedge clk);
    #1;

    // Reset during the strobe phase of a write.
    av_addr[0] = 2'd2; av_wr[0] = 1'b1; av_wd[0] = 16'h55AA;
    repeat (4) @(posedge clk);
    #1;
    check_val("pre-reset wr_n", 32'(wrn[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check_val("abort ctl", 32'({csn[0], wrn[0], oe[0]}), 32'(3'b110));
    check_val("abort rdata", 32'(rdata[0]), 32'd0);
    exp_rd[0] = 16'd0;
    exp_rd[1] = 16'd0;
    av_wr[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run_txn(0, 1'b0, 2'd1, 16'($urandom));

    // Interrupt path.
    oint[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
`ifdef OTG_HPI_IRQ_SYNC_EN
      check_val($sformatf("irq c%0d", c), 32'(irq[0]), 32'(c >= 2));
`else
      check_val($sformatf("irq tied c%0d", c), 32'(irq[0]), 32'd0);
`endif
      @(posedge clk);
      #1;
    end
    oint[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("irq clear", 32'(irq[0]), 32'd0);

    for (int i = 0; i < 16; i++) begin
      run_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
